// File: rtl/btn_conditioner.sv
// btn_conditioner: debounces a raw push-button and turns each press into
// single-cycle enables.
//
// Ports
//   board_clk  system clock, rising edge
//   reset      asynchronous, active-high
//   PB         raw bouncy button level (asynchronous)
//   DPB        debounced button level
//   SCEN       one-cycle pulse per accepted press
//   MCEN       one-cycle pulse per press, plus auto-repeat pulses while held
//   state      FSM state for debug LEDs (INI=000 WQ=001 SCEN_ST=010 HOLD=011 WR=100)
//
// Build option: define BTN_COND_REPEAT_EN to enable MCEN auto-repeat every
// REPEAT_CYCLES cycles while the button stays held. Without it MCEN == SCEN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic [2:0] state
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 27)) begin : g_db_chk
    $error("DEBOUNCE_CYCLES must be in 2..2^27");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > (1 << 27)) begin : g_rp_chk
    $error("REPEAT_CYCLES must be in 2..2^27");
  end

  typedef enum logic [2:0] {
    INI     = 3'b000,
    WQ      = 3'b001,
    SCEN_ST = 3'b010,
    HOLD    = 3'b011,
    WR      = 3'b100
  } st_t;

  localparam logic [26:0] DB_LAST = 27'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_COND_REPEAT_EN
  localparam logic [26:0] RP_LAST = 27'(REPEAT_CYCLES - 1);
  logic rpt_pulse;
`endif

  st_t         cur_st, nxt_st;
  logic [26:0] cnt, cnt_nxt;
  logic        pb_s1, pb_s2;   // pb_s2 is the synchronized level the FSM uses

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      pb_s1  <= 1'b0;
      pb_s2  <= 1'b0;
      cur_st <= INI;
      cnt    <= '0;
    end else begin
      pb_s1  <= PB;
      pb_s2  <= pb_s1;
      cur_st <= nxt_st;
      cnt    <= cnt_nxt;
    end
  end

  // The counter only ever counts up to a compare value and is cleared on
  // every state change, so it cannot wrap.
  always_comb begin
    nxt_st  = cur_st;
    cnt_nxt = cnt;
`ifdef BTN_COND_REPEAT_EN
    rpt_pulse = 1'b0;
`endif
    case (cur_st)
      INI: begin
        cnt_nxt = '0;
        if (pb_s2) nxt_st = WQ;
      end
      WQ: begin
        if (!pb_s2) begin
          nxt_st  = INI;
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          nxt_st  = SCEN_ST;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 27'd1;
        end
      end
      SCEN_ST: begin
        nxt_st  = HOLD;
        cnt_nxt = '0;
      end
      HOLD: begin
        if (!pb_s2) begin
          nxt_st  = WR;
          cnt_nxt = '0;
        end else begin
`ifdef BTN_COND_REPEAT_EN
          if (cnt == RP_LAST) begin
            cnt_nxt   = '0;
            rpt_pulse = 1'b1;
          end else begin
            cnt_nxt = cnt + 27'd1;
          end
`else
          cnt_nxt = cnt;
`endif
        end
      end
      WR: begin
        if (pb_s2) begin
          nxt_st  = HOLD;
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          nxt_st  = INI;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 27'd1;
        end
      end
      default: begin
        // upset into an unused encoding: recover to idle
        nxt_st  = INI;
        cnt_nxt = '0;
      end
    endcase
  end

  assign state = cur_st;
  assign SCEN  = (cur_st == SCEN_ST);
  assign DPB   = (cur_st != INI) && (cur_st != WQ);
`ifdef BTN_COND_REPEAT_EN
  assign MCEN  = SCEN | rpt_pulse;
`else
  assign MCEN  = SCEN;
`endif

endmodule
